// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: data width, canonical NOP, fetch FSM states
// and the decode-facing instruction buffer entry.
`default_nettype none

package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_entry_t;
endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of if_entry_t with push/pop/flush and occupancy out.
// Rev 1.0
`default_nettype none

module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  if_entry_t                push_data,
  input  logic                     pop,
  output if_entry_t                head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush) assert (!(push && !pop && count == CW'(DEPTH)));
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

`default_nettype wire

// File: rtl/instruc_fetch.sv
// instruc_fetch: PC, credit-limited imem requests, branch redirect with stale-response drain.
// Rev 1.0
`default_nettype none

module instruc_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [XLEN-1:0]  imem_rsp_data,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [XLEN-1:0]  if_instr,
  output logic [XLEN-1:0]  if_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_shadow;
  logic [CW-1:0]   in_flight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   in_flight_nxt;
  logic [CW:0]     credits_used;
  logic [XLEN-1:0] target_pc;
  logic            req_hs;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  if_entry_t       push_data;
  if_entry_t       head;
  logic            unused_align_bits;

  assign unused_align_bits = ^redirect_pc[1:0];
  assign target_pc         = {redirect_pc[XLEN-1:2], 2'b00};

  // Credits cover both outstanding requests and buffered words, so the FIFO cannot overflow.
  assign credits_used   = {1'b0, in_flight} + {1'b0, fifo_count};
  assign imem_req_valid = rst_n && !redirect && (credits_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign push          = imem_rsp_valid && (state == FETCH) && !redirect;
  assign pop           = if_valid && if_ready;
  assign in_flight_nxt = in_flight + CW'(req_hs) - CW'(imem_rsp_valid);

  assign push_data.instr = imem_rsp_data;
  assign push_data.pc    = pc_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC;
      pc_shadow <= RESET_PC;
      in_flight <= '0;
      drop_cnt  <= '0;
    end else begin
      in_flight <= in_flight_nxt;
      if (redirect) begin
        fetch_pc  <= target_pc;
        pc_shadow <= target_pc;
        drop_cnt  <= in_flight_nxt;
        state     <= (in_flight_nxt != '0) ? DRAIN : FETCH;
      end else begin
        if (req_hs) fetch_pc  <= fetch_pc + 32'd4;
        if (push)   pc_shadow <= pc_shadow + 32'd4;
        if (state == DRAIN && imem_rsp_valid) begin
          drop_cnt <= drop_cnt - CW'(1);
          if (drop_cnt == CW'(1)) state <= FETCH;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_rsp_valid && in_flight == '0));
      assert (!(imem_rsp_valid && state == DRAIN && drop_cnt == '0));
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign if_valid = !fifo_empty;
  assign if_instr = fifo_empty ? NOP_INSTR : head.instr;
  assign if_pc    = fifo_empty ? pc_shadow : head.pc;
endmodule

`default_nettype wire
